// File: rtl/packet_pkg.sv
// rtl/packet_pkg.sv - shared state encoding, constants and byte-enable helpers for the packet sink
package packet_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      IN_PKT = 1'b1
   } state_t;

   localparam int          BYTES_PER_WORD = 8;
   localparam logic [15:0] ETH_TYPE_VLAN  = 16'h8100;

   function automatic logic [3:0] be_popcount(input logic [7:0] be);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, be[i]};
      end
      return n;
   endfunction

   // Legal tail masks fill from byte 0 (bit 7) downward with no holes.
   function automatic logic be_is_contiguous(input logic [7:0] be);
      logic [7:0] inv;
      inv = ~be;
      return be[7] && ((inv & (inv + 8'd1)) == 8'd0);
   endfunction

endpackage

// File: rtl/modport_sink_len.sv
// rtl/modport_sink_len.sv - beat index counter and saturating packet byte length
module modport_sink_len
   import packet_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   input  logic        i_accum,
   input  logic [7:0]  i_be,
   output logic [15:0] o_beat_idx,
   output logic [15:0] o_len
);

   logic [15:0] r_beats;
   logic [19:0] w_len_full;

   assign o_beat_idx = i_start ? 16'd0 : r_beats;
   assign w_len_full = 20'(o_beat_idx) * 20'(BYTES_PER_WORD) + 20'(be_popcount(i_be));
   assign o_len      = (w_len_full > 20'h0FFFF) ? 16'hFFFF : w_len_full[15:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_beats <= 16'd0;
      end else if (i_start) begin
         r_beats <= 16'd1;
      end else if (i_accum && (r_beats != 16'hFFFF)) begin
         r_beats <= r_beats + 16'd1;
      end
   end

endmodule

// File: rtl/modport_sink.sv
// rtl/modport_sink.sv - Ethernet header dissector on a 64-bit packet stream; VLAN_PARSE_EN adds 802.1Q parsing
module modport_sink
   import packet_pkg::*;
#(
   parameter int MIN_LEN = 14,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid,
   input  logic [63:0]      data,
   input  logic [7:0]       byte_enable,
   input  logic             sop,
   input  logic             eop,
   output logic             hdr_valid,
   output logic [47:0]      dst_mac,
   output logic [47:0]      src_mac,
   output logic [15:0]      ethertype,
   output logic [15:0]      pkt_len,
   output logic             err_runt,
   output logic             err_proto,
`ifdef VLAN_PARSE_EN
   output logic [15:0]      vlan_tci,
`endif
   output logic [CNT_W-1:0] pkt_count
);

   localparam logic [15:0] RUNT_STD = 16'(MIN_LEN);

   state_t      r_state, w_next_state;
   logic        w_start, w_cont, w_stray, w_final, w_proto, w_runt;
   logic [63:0] w_be_mask, w_dm;
   logic [15:0] w_beat_idx, w_len, w_type_out;
   logic [47:0] r_dst, r_src, w_dst_n, w_src_n;
   logic [15:0] r_b1213, w_b1213_n;
`ifdef VLAN_PARSE_EN
   localparam logic [15:0] RUNT_VLAN = 16'(MIN_LEN + 4);
   logic [15:0] r_tci, r_et2, w_tci_n, w_et2_n;
   logic        w_tagged;
`endif

   always_comb begin
      w_next_state = r_state;
      w_start      = valid && sop;
      w_cont       = valid && !sop && (r_state == IN_PKT);
      w_stray      = valid && !sop && (r_state == IDLE);
      w_final      = (w_start || w_cont) && eop;
      if (w_start && !eop) begin
         w_next_state = IN_PKT;
      end else if (w_final) begin
         w_next_state = IDLE;
      end
      w_proto = w_stray || (w_start && (r_state == IN_PKT)) ||
                ((w_start || w_cont) &&
                 (eop ? !be_is_contiguous(byte_enable) : (byte_enable != 8'hFF)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   modport_sink_len u_len (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_start    (w_start),
      .i_accum    (w_cont),
      .i_be       (byte_enable),
      .o_beat_idx (w_beat_idx),
      .o_len      (w_len)
   );

   // Disabled byte lanes are zeroed so bytes never received read as 0.
   always_comb begin
      w_be_mask = '0;
      for (int i = 0; i < 8; i++) begin
         w_be_mask[8*i +: 8] = {8{byte_enable[i]}};
      end
      w_dm = data & w_be_mask;
   end

   always_comb begin
      w_dst_n   = w_start ? 48'd0 : r_dst;
      w_src_n   = w_start ? 48'd0 : r_src;
      w_b1213_n = w_start ? 16'd0 : r_b1213;
`ifdef VLAN_PARSE_EN
      w_tci_n   = w_start ? 16'd0 : r_tci;
      w_et2_n   = w_start ? 16'd0 : r_et2;
`endif
      if (w_start || w_cont) begin
         case (w_beat_idx)
            16'd0: begin
               w_dst_n         = w_dm[63:16];
               w_src_n[47:32]  = w_dm[15:0];
            end
            16'd1: begin
               w_src_n[31:0]   = w_dm[63:32];
               w_b1213_n       = w_dm[31:16];
`ifdef VLAN_PARSE_EN
               w_tci_n         = w_dm[15:0];
`endif
            end
`ifdef VLAN_PARSE_EN
            16'd2: w_et2_n     = w_dm[63:48];
`endif
            default: ;
         endcase
      end
`ifdef VLAN_PARSE_EN
      w_tagged   = (w_b1213_n == ETH_TYPE_VLAN);
      w_type_out = w_tagged ? w_et2_n : w_b1213_n;
      w_runt     = w_len < (w_tagged ? RUNT_VLAN : RUNT_STD);
`else
      w_type_out = w_b1213_n;
      w_runt     = w_len < RUNT_STD;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dst     <= '0;
         r_src     <= '0;
         r_b1213   <= '0;
`ifdef VLAN_PARSE_EN
         r_tci     <= '0;
         r_et2     <= '0;
`endif
      end else if (w_start || w_cont) begin
         r_dst     <= w_dst_n;
         r_src     <= w_src_n;
         r_b1213   <= w_b1213_n;
`ifdef VLAN_PARSE_EN
         r_tci     <= w_tci_n;
         r_et2     <= w_et2_n;
`endif
      end
   end

   // Result fields hold until the next finalized packet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hdr_valid <= 1'b0;
         err_proto <= 1'b0;
         dst_mac   <= '0;
         src_mac   <= '0;
         ethertype <= '0;
         pkt_len   <= '0;
         err_runt  <= 1'b0;
         pkt_count <= '0;
`ifdef VLAN_PARSE_EN
         vlan_tci  <= '0;
`endif
      end else begin
         hdr_valid <= w_final;
         err_proto <= w_proto;
         if (w_final) begin
            dst_mac   <= w_dst_n;
            src_mac   <= w_src_n;
            ethertype <= w_type_out;
            pkt_len   <= w_len;
            err_runt  <= w_runt;
            pkt_count <= pkt_count + CNT_W'(1);
`ifdef VLAN_PARSE_EN
            vlan_tci  <= w_tagged ? w_tci_n : 16'd0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_modport_sink.sv
// tb/tb_modport_sink.sv - scoreboard bench for modport_sink; VLAN_PARSE_EN enables the tagged-packet case
module tb_modport_sink;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid;
   logic [63:0] data;
   logic [7:0]  byte_enable;
   logic        sop, eop;
   logic        hdr_valid, err_runt, err_proto;
   logic [47:0] dst_mac, src_mac;
   logic [15:0] ethertype, pkt_len;
   logic [31:0] pkt_count;
`ifdef VLAN_PARSE_EN
   logic [15:0] vlan_tci;
`endif

   modport_sink #(.MIN_LEN(14), .CNT_W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid       (valid),
      .data        (data),
      .byte_enable (byte_enable),
      .sop         (sop),
      .eop         (eop),
      .hdr_valid   (hdr_valid),
      .dst_mac     (dst_mac),
      .src_mac     (src_mac),
      .ethertype   (ethertype),
      .pkt_len     (pkt_len),
      .err_runt    (err_runt),
      .err_proto   (err_proto),
`ifdef VLAN_PARSE_EN
      .vlan_tci    (vlan_tci),
`endif
      .pkt_count   (pkt_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [47:0] dst;
      logic [47:0] src;
      logic [15:0] et;
      logic [15:0] len;
      logic        runt;
      logic [15:0] tci;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  pb[$];
   int          checks = 0;
   int          failures = 0;
   int          exp_count = 0;
   int          proto_seen = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] pbyte(input int i);
      return (i < pb.size()) ? pb[i] : 8'h00;
   endfunction

   function automatic exp_t model_pkt();
      exp_t e;
      int   n;
      n      = pb.size();
      e.dst  = {pbyte(0), pbyte(1), pbyte(2), pbyte(3), pbyte(4), pbyte(5)};
      e.src  = {pbyte(6), pbyte(7), pbyte(8), pbyte(9), pbyte(10), pbyte(11)};
      e.et   = {pbyte(12), pbyte(13)};
      e.len  = (n > 65535) ? 16'hFFFF : 16'(n);
      e.tci  = 16'h0000;
      e.runt = (n < 14);
`ifdef VLAN_PARSE_EN
      if (e.et == 16'h8100) begin
         e.tci  = {pbyte(14), pbyte(15)};
         e.et   = {pbyte(16), pbyte(17)};
         e.runt = (n < 18);
      end
`endif
      return e;
   endfunction

   // Drives the first nbeats beats of pb; eop only if the whole packet is sent.
   task automatic drive_beats(input int nbeats, input bit push);
      int n, total;
      logic [63:0] d;
      logic [7:0]  be;
      n     = pb.size();
      total = (n + 7) / 8;
      if (push) exp_q.push_back(model_pkt());
      for (int b = 0; b < nbeats; b++) begin
         d  = '0;
         be = '0;
         for (int k = 0; k < 8; k++) begin
            if (b*8 + k < n) begin
               d[63 - 8*k -: 8] = pb[b*8 + k];
               be[7 - k]        = 1'b1;
            end
         end
         valid = 1'b1; data = d; byte_enable = be;
         sop = (b == 0); eop = (b == total - 1);
         @(posedge clk); #1;
      end
      valid = 1'b0; sop = 1'b0; eop = 1'b0;
   endtask

   task automatic send_pkt();
      drive_beats((pb.size() + 7) / 8, 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic load_eth14();
      pb = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
             8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h08, 8'h00};
   endtask

   task automatic load_random(input int n);
      pb.delete();
      for (int i = 0; i < n; i++) pb.push_back(8'($urandom));
   endtask

   always @(negedge clk) begin
      if (rst_n && err_proto) proto_seen++;
      if (rst_n && hdr_valid) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_hdr_valid", 64'(exp_q.size()), 64'd1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            exp_count++;
            check_val("dst_mac",   64'(dst_mac),   64'(e.dst));
            check_val("src_mac",   64'(src_mac),   64'(e.src));
            check_val("ethertype", 64'(ethertype), 64'(e.et));
            check_val("pkt_len",   64'(pkt_len),   64'(e.len));
            check_val("err_runt",  64'(err_runt),  64'(e.runt));
            check_val("pkt_count", 64'(pkt_count), 64'(exp_count));
`ifdef VLAN_PARSE_EN
            check_val("vlan_tci",  64'(vlan_tci),  64'(e.tci));
`endif
         end
      end
   end

   initial begin
      rst_n = 1'b0; valid = 1'b0; data = '0; byte_enable = '0; sop = 1'b0; eop = 1'b0;
      idle(2);
      check_val("rst_hdr_valid", 64'(hdr_valid), 64'd0);
      check_val("rst_dst_mac",   64'(dst_mac),   64'd0);
      check_val("rst_src_mac",   64'(src_mac),   64'd0);
      check_val("rst_ethertype", 64'(ethertype), 64'd0);
      check_val("rst_pkt_len",   64'(pkt_len),   64'd0);
      check_val("rst_err_runt",  64'(err_runt),  64'd0);
      check_val("rst_err_proto", 64'(err_proto), 64'd0);
      check_val("rst_pkt_count", 64'(pkt_count), 64'd0);
      rst_n = 1'b1;
      idle(1);

      load_eth14();
      send_pkt();
      idle(2);

      pb = '{8'hAA, 8'hBB, 8'hCC};
      send_pkt();
      idle(2);

      load_random(64);
      send_pkt();
      load_eth14();
      send_pkt();
      idle(2);
      check_val("count_after_b2b", 64'(pkt_count), 64'd4);
      check_val("proto_clean", 64'(proto_seen), 64'd0);

      valid = 1'b1; sop = 1'b0; eop = 1'b0; data = 64'h0123456789ABCDEF; byte_enable = 8'hFF;
      idle(1);
      valid = 1'b0;
      idle(2);
      check_val("proto_stray", 64'(proto_seen), 64'd1);
      check_val("count_stray", 64'(pkt_count), 64'd4);

      load_random(24);
      drive_beats(2, 1'b0);
      load_random(20);
      send_pkt();
      idle(2);
      check_val("proto_abort", 64'(proto_seen), 64'd2);
      check_val("count_abort", 64'(pkt_count), 64'd5);

      // Holed tail mask: bytes 0 and 2 counted, packet still finalized.
      exp_q.push_back('{dst: 48'h110033000000, src: 48'h0, et: 16'h0, len: 16'd2,
                        runt: 1'b1, tci: 16'h0});
      valid = 1'b1; sop = 1'b1; eop = 1'b1; data = 64'h1122334455667788; byte_enable = 8'hA0;
      idle(1);
      valid = 1'b0; sop = 1'b0; eop = 1'b0;
      idle(2);
      check_val("proto_bad_be", 64'(proto_seen), 64'd3);

      load_random(65600);
      send_pkt();
      idle(2);

      load_eth14();
      drive_beats(1, 1'b0);
      rst_n = 1'b0;
      #2;
      check_val("mid_rst_hdr_valid", 64'(hdr_valid), 64'd0);
      check_val("mid_rst_pkt_count", 64'(pkt_count), 64'd0);
      check_val("mid_rst_dst_mac",   64'(dst_mac),   64'd0);
      check_val("mid_rst_pkt_len",   64'(pkt_len),   64'd0);
      exp_count = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(1);
      load_eth14();
      send_pkt();
      idle(2);
      check_val("count_after_rst", 64'(pkt_count), 64'd1);

`ifdef VLAN_PARSE_EN
      load_random(20);
      pb[12] = 8'h81; pb[13] = 8'h00; pb[14] = 8'h00; pb[15] = 8'h64;
      pb[16] = 8'h86; pb[17] = 8'hDD;
      send_pkt();
      idle(2);
      check_val("vlan_tci_direct",  64'(vlan_tci),  64'h0064);
      check_val("vlan_type_direct", 64'(ethertype), 64'h86DD);
`endif

      idle(3);
      check_val("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/modport_sink.md
Name: modport_sink

Overview:
- Ethernet header dissector on the sink side of the 64-bit packet stream bus: valid, data, byte_enable, sop, eop.
- Consumes beats unconditionally; the bus has no ready, so there is no backpressure.
- Extracts destination MAC, source MAC, EtherType and packet byte length, and flags runt and protocol errors.
- Sits directly behind a packet source. Results go to downstream classification logic.

Parameters:
- MIN_LEN, 14: minimum legal packet length in bytes; shorter packets raise err_runt.
- CNT_W, 32: width of the accepted-packet counter.

Ports:
- clk  in  1  rising-edge clock; the single clock of the block.
- rst_n  in  1  asynchronous, active-low reset.
- valid  in  1  beat qualifier.
- data  in  64  beat payload, big-endian: byte 0 in [63:56], byte 7 in [7:0].
- byte_enable  in  8  bit 7 qualifies byte 0, bit 0 qualifies byte 7.
- sop  in  1  first beat of a packet.
- eop  in  1  last beat of a packet.
- hdr_valid  out  1  one-cycle pulse; result fields are valid.
- dst_mac  out  48  packet bytes 0-5.
- src_mac  out  48  packet bytes 6-11.
- ethertype  out  16  bytes 12-13, or 16-17 when VLAN-tagged with VLAN_PARSE_EN.
- pkt_len  out  16  packet length in bytes.
- err_runt  out  1  qualified by hdr_valid; pkt_len < MIN_LEN.
- err_proto  out  1  one-cycle pulse on a bus protocol violation.
- pkt_count  out  CNT_W  count of hdr_valid pulses.

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE and internal field/length registers clear.
- Reset mid-packet: the partial packet is discarded with no hdr_valid.
- FSM states: IDLE, IN_PKT.
- IDLE:
  - valid&sop&eop: single-beat packet, finalize, stay in IDLE.
  - valid&sop&!eop: clear fields, beat_idx=0, go to IN_PKT.
  - valid&!sop: err_proto pulse, beat dropped.
- IN_PKT:
  - valid&!sop&!eop: accumulate.
  - valid&eop: finalize, go to IDLE.
  - valid&sop: err_proto pulse, current packet aborted without hdr_valid, new packet started from this beat.
  - valid low: idle gap, state held.
- Byte_enable rules:
  - Non-eop beats must be 0xFF.
  - Eop beat must be non-zero and MSB-contiguous (0x80, 0xC0, ... 0xFF).
  - Any other value gives an err_proto pulse; the packet is still finalized, counting popcount(byte_enable).
- Field capture by beat_idx:
  - Beat 0: dst_mac=data[63:16], src_mac[47:32]=data[15:0].
  - Beat 1: src_mac[31:0]=data[63:32], ethertype=data[31:16].
  - Bytes never received read as 0.
- Length:
  - pkt_len = 8*(beats-1) + popcount(eop byte_enable).
  - Saturates at 0xFFFF; beat_idx saturates rather than wraps.
- Latency: hdr_valid, fields, pkt_len and err_runt are registered and appear 1 cycle after the eop beat. They hold until the next hdr_valid.
- pkt_count increments with each hdr_valid, including runts; it wraps at 2^CNT_W.
- Back-to-back packets (eop beat immediately followed by a sop beat) are supported with no idle cycle.

Optional Feature:
- Macro: VLAN_PARSE_EN.
- Defined:
  - If bytes 12-13 equal 0x8100, add output vlan_tci[15:0] = bytes 14-15 (beat 1 data[15:0]).
  - ethertype becomes bytes 16-17 (beat 2 data[63:48]).
  - Runt threshold becomes MIN_LEN+4.
  - vlan_tci reads 0 for untagged packets.
- Undefined: no vlan_tci port, and 0x8100 is reported as a plain EtherType.

Decomposition:
- Package packet_pkg holds:
  - state enum (IDLE, IN_PKT);
  - constants BYTES_PER_WORD=8, ETH_TYPE_VLAN=16'h8100;
  - function be_popcount(logic[7:0]);
  - function be_is_contiguous(logic[7:0]).
- One sub-module, modport_sink_len, containing the beat counter, the popcount and the saturating pkt_len.

Test Plan:
- 14-byte packet:
  - Stimulus: beat0 0xFFFFFFFFFFFF0011, be 0xFF, sop; beat1 0x2233445508000000, be 0xFC, eop.
  - Next cycle: hdr_valid=1, dst_mac=0xFFFFFFFFFFFF, src_mac=0x001122334455, ethertype=0x0800, pkt_len=14, err_runt=0, pkt_count=1.
- 3-byte packet:
  - Stimulus: single beat with sop=eop=1, be 0xE0.
  - Response: pkt_len=3, err_runt=1, hdr_valid pulses.
- 64-byte packet:
  - Stimulus: 8 beats, last be 0xFF, followed immediately by another 14-byte packet.
  - Response: pkt_len=64 then 14, two hdr_valid pulses, pkt_count=2.
- Protocol error, stray beat: valid without sop in IDLE → err_proto pulse, no hdr_valid, pkt_count unchanged.
- Protocol error, abort: sop mid-packet → err_proto pulse, first packet aborted, second packet reported normally.
- Reset mid-packet: rst_n low after beat0 → all outputs 0 and no hdr_valid; a subsequent 14-byte packet reports correctly.
- VLAN (VLAN_PARSE_EN):
  - Stimulus: bytes 12-13 0x8100, TCI 0x0064, bytes 16-17 0x86DD, 20-byte packet.
  - Response: vlan_tci=0x0064, ethertype=0x86DD, err_runt=0.
